// File: rtl/sr_loader_pkg.sv
// Shared definitions for the schoolRISCV program loader: state encoding,
// frame constants and the fetch fallback instruction.
package sr_loader_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CNT_LO = 3'd1;
   localparam logic [2:0] ST_CNT_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_WRITE  = 3'd4;
   localparam logic [2:0] ST_CSUM   = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_CNT_LO = ST_CNT_LO,
      S_CNT_HI = ST_CNT_HI,
      S_DATA   = ST_DATA,
      S_WRITE  = ST_WRITE,
      S_CSUM   = ST_CSUM,
      S_ERR    = ST_ERR
   } state_t;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
   localparam logic [31:0] NOP_INSTR         = 32'h00000013;
   localparam int          COUNT_WIDTH       = 16;

endpackage

// File: rtl/sr_imem_ram.sv
// Instruction word RAM: one synchronous write port, one combinational read
// port, contents survive reset.
module sr_imem_ram #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [31:0]           wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Framed byte-stream loader feeding the instruction RAM; keeps the core in
// reset until a frame with a matching XOR checksum has been stored.
module sr_imem_loader
   import sr_loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 6,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  inData,
   input  logic        inValid,
   output logic        inReady,
   input  logic [31:0] imAddr,
   output logic [31:0] imData,
   output logic        cpuRst_n,
   output logic        busy,
   output logic        error
);

   localparam logic [31:0] DEPTH = 32'(2**ADDR_WIDTH);

   state_t                 state_reg, state_next;
   logic [COUNT_WIDTH-1:0] count_reg, count_next;
   logic [1:0]             byte_idx_reg, byte_idx_next;
   logic [ADDR_WIDTH-1:0]  word_addr_reg, word_addr_next;
   logic [31:0]            word_reg, word_next;
   logic [7:0]             csum_reg, csum_next;
   logic                   cpu_rst_n_reg, cpu_rst_n_next;
   logic                   busy_reg, busy_next;
   logic                   error_reg, error_next;

   logic                   accept;
   logic                   ram_we;
   logic [COUNT_WIDTH-1:0] count_full;
   logic [31:0]            ram_rdata;

   assign inReady    = (state_reg != S_WRITE);
   assign accept     = inValid & inReady;
   assign count_full = {inData, count_reg[7:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         count_reg     <= '0;
         byte_idx_reg  <= '0;
         word_addr_reg <= '0;
         word_reg      <= '0;
         csum_reg      <= '0;
         cpu_rst_n_reg <= 1'b0;
         busy_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         byte_idx_reg  <= byte_idx_next;
         word_addr_reg <= word_addr_next;
         word_reg      <= word_next;
         csum_reg      <= csum_next;
         cpu_rst_n_reg <= cpu_rst_n_next;
         busy_reg      <= busy_next;
         error_reg     <= error_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      byte_idx_next  = byte_idx_reg;
      word_addr_next = word_addr_reg;
      word_next      = word_reg;
      csum_next      = csum_reg;
      cpu_rst_n_next = cpu_rst_n_reg;
      busy_next      = busy_reg;
      error_next     = error_reg;
      ram_we         = 1'b0;

      case (state_reg)
         // IDLE and ERR both restart on a sync byte; anything else is dropped.
         S_IDLE, S_ERR: begin
            if (accept && inData == SYNC_BYTE) begin
               state_next     = S_CNT_LO;
               cpu_rst_n_next = 1'b0;
               busy_next      = 1'b1;
               error_next     = 1'b0;
            end
         end
         S_CNT_LO: begin
            if (accept) begin
               count_next[7:0] = inData;
               state_next      = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (accept) begin
               count_next = count_full;
               if (count_full == '0 || 32'(count_full) > DEPTH) begin
                  state_next = S_ERR;
                  error_next = 1'b1;
                  busy_next  = 1'b0;
               end else begin
                  state_next     = S_DATA;
                  byte_idx_next  = '0;
                  word_addr_next = '0;
                  csum_next      = '0;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               word_next[8*byte_idx_reg +: 8] = inData;
               csum_next     = csum_reg ^ inData;
               byte_idx_next = byte_idx_reg + 2'd1;
               if (byte_idx_reg == 2'd3)
                  state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            ram_we = 1'b1;
            if (COUNT_WIDTH'(word_addr_reg) == count_reg - 1'b1) begin
               state_next = S_CSUM;
            end else begin
               word_addr_next = word_addr_reg + 1'b1;
               state_next     = S_DATA;
            end
         end
         S_CSUM: begin
            if (accept) begin
               busy_next = 1'b0;
               if (inData == csum_reg) begin
                  state_next     = S_IDLE;
                  cpu_rst_n_next = 1'b1;
               end else begin
                  state_next = S_ERR;
                  error_next = 1'b1;
               end
            end
         end
         default: begin
            state_next     = S_IDLE;
            cpu_rst_n_next = 1'b0;
            busy_next      = 1'b0;
         end
      endcase
   end

   sr_imem_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (word_addr_reg),
      .wdata (word_reg),
      .raddr (imAddr[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   // Fetches outside the RAM window execute as NOPs.
   assign imData   = (imAddr[31:ADDR_WIDTH] == '0) ? ram_rdata : NOP_INSTR;
   assign cpuRst_n = cpu_rst_n_reg;
   assign busy     = busy_reg;
   assign error    = error_reg;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Directed bench for sr_imem_loader: table of bytes with expected status after
// each, plus hand sequences for handshake stalls, reset mid-load and fetch range.
module tb_sr_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  inData = 8'h00;
   logic        inValid = 1'b0;
   logic        inReady;
   logic [31:0] imAddr = 32'h0;
   logic [31:0] imData;
   logic        cpuRst_n;
   logic        busy;
   logic        error;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sr_imem_loader #(
      .ADDR_WIDTH(6),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .inData   (inData),
      .inValid  (inValid),
      .inReady  (inReady),
      .imAddr   (imAddr),
      .imData   (imData),
      .cpuRst_n (cpuRst_n),
      .busy     (busy),
      .error    (error)
   );

   typedef struct {
      logic [7:0] data;
      logic       exp_busy;
      logic       exp_cpu;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Present one byte until accepted; returns 1 ns after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      inData  = b;
      inValid = 1'b1;
      forever begin
         @(negedge clk);
         if (inReady) break;
         waited++;
         if (waited > 10) begin
            check("accept_timeout", 32'(inReady), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic add(input logic [7:0] d, input logic b, input logic c, input logic e);
      vec_t v;
      v.data = d; v.exp_busy = b; v.exp_cpu = c; v.exp_err = e;
      vecs.push_back(v);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         send_byte(vecs[i].data);
         $display("byte[%0d]=%h busy=%b cpuRst_n=%b error=%b", i, vecs[i].data, busy, cpuRst_n, error);
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check($sformatf("v%0d_cpu", i), 32'(cpuRst_n), 32'(vecs[i].exp_cpu));
         check($sformatf("v%0d_err", i), 32'(error), 32'(vecs[i].exp_err));
      end
   endtask

   task automatic read_word(input logic [31:0] a, input string name, input logic [31:0] exp);
      imAddr = a;
      #1;
      check(name, imData, exp);
   endtask

   logic [7:0] t2_bytes [0:11];

   initial begin
      // Segment A (vectors 0-7): single-word load, ram[0]=00100513, csum 06.
      add(8'hA5, 1, 0, 0); add(8'h01, 1, 0, 0); add(8'h00, 1, 0, 0);
      add(8'h13, 1, 0, 0); add(8'h05, 1, 0, 0); add(8'h10, 1, 0, 0);
      add(8'h00, 1, 0, 0); add(8'h06, 0, 1, 0);
      // Segment B (8-15): bad checksum while core running -> reload then ERR.
      add(8'hA5, 1, 0, 0); add(8'h01, 1, 0, 0); add(8'h00, 1, 0, 0);
      add(8'h13, 1, 0, 0); add(8'h05, 1, 0, 0); add(8'h10, 1, 0, 0);
      add(8'h00, 1, 0, 0); add(8'hFF, 0, 0, 1);
      // 16-23: sync out of ERR clears error; DEADBEEF with csum 22.
      add(8'hA5, 1, 0, 0); add(8'h01, 1, 0, 0); add(8'h00, 1, 0, 0);
      add(8'hEF, 1, 0, 0); add(8'hBE, 1, 0, 0); add(8'hAD, 1, 0, 0);
      add(8'hDE, 1, 0, 0); add(8'h22, 0, 1, 0);
      // 24-29: count=0 and count=65 both land in ERR.
      add(8'hA5, 1, 0, 0); add(8'h00, 1, 0, 0); add(8'h00, 0, 0, 1);
      add(8'hA5, 1, 0, 0); add(8'h41, 1, 0, 0); add(8'h00, 0, 0, 1);

      t2_bytes = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                   8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44};

      repeat (2) @(posedge clk);
      #1;
      check("rst_cpu", 32'(cpuRst_n), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(error), 32'd0);
      check("rst_ready", 32'(inReady), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Test 1
      run_vecs(0, 7);
      read_word(32'h0, "t1_ram0", 32'h00100513);

      // Test 2: two words, valid low every other cycle, one-cycle WRITE stall.
      for (int i = 0; i < 12; i++) begin
         send_byte(t2_bytes[i]);
         $display("t2 byte[%0d]=%h busy=%b ready=%b", i, t2_bytes[i], busy, inReady);
         if (i == 6 || i == 10) check($sformatf("t2_stall%0d", i), 32'(inReady), 32'd0);
         if (i < 11) check($sformatf("t2_busy%0d", i), 32'(busy), 32'd1);
         else        check("t2_done_busy", 32'(busy), 32'd0);
         @(posedge clk);
         #1;
         if (i == 6 || i == 10) check($sformatf("t2_unstall%0d", i), 32'(inReady), 32'd1);
      end
      check("t2_cpu", 32'(cpuRst_n), 32'd1);
      read_word(32'h0, "t2_ram0", 32'h11223344);
      read_word(32'h1, "t2_ram1", 32'hAABBCCDD);

      // Tests 3 and 4
      run_vecs(8, 29);
      read_word(32'h0, "t4_ram0", 32'hDEADBEEF);
      read_word(32'h1, "t4_ram1", 32'hAABBCCDD);

      // Test 5: reset after two data bytes of a one-word frame.
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h77); send_byte(8'h66);
      rst = 1'b1;
      #2;
      $display("t5 reset busy=%b cpuRst_n=%b error=%b", busy, cpuRst_n, error);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_cpu", 32'(cpuRst_n), 32'd0);
      check("t5_err", 32'(error), 32'd0);
      check("t5_ready", 32'(inReady), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_vecs(0, 7);
      read_word(32'h0, "t5_ram0", 32'h00100513);

      // Test 6: out-of-range fetch and a stray byte while running.
      read_word(32'h00000040, "t6_nop40", 32'h00000013);
      read_word(32'h80000000, "t6_nophi", 32'h00000013);
      read_word(32'h00000001, "t6_ram1", 32'hAABBCCDD);
      send_byte(8'h00);
      $display("t6 garbage byte busy=%b cpuRst_n=%b", busy, cpuRst_n);
      check("t6_cpu", 32'(cpuRst_n), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("t6_cpu_hold", 32'(cpuRst_n), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
